// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - 32x32 multiply sequencer over a shared registered 16x16 multiplier cell
module mul_seq_ctrl #(
    parameter int MC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [15:0] mc_a,
    output logic [15:0] mc_b,
    output logic        mc_en,
    input  logic [31:0] mc_p
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [1:0]  k_q;
    logic [63:0] acc_q;
    logic [63:0] acc_next;
    logic [63:0] pp_shifted;
    logic [31:0] result_q;
    logic [31:0] hi_fix;
    logic        tag_v [1:MC_LATENCY];
    logic [1:0]  tag_k [1:MC_LATENCY];
    logic        tag_out_v;
    logic [1:0]  tag_out_k;
    logic        accept;
    logic        issue;
    logic        is_mulx;
    logic [1:0]  last_k;

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign issue     = (state == S_ISSUE);
    assign is_mulx   = (op_q != 2'b00);
    assign last_k    = is_mulx ? 2'd3 : 2'd2;
    assign tag_out_v = tag_v[MC_LATENCY];
    assign tag_out_k = tag_k[MC_LATENCY];

    // Partial product alignment: k=0 at bit 0, cross terms at bit 16, a_hi*b_hi at bit 32
    always_comb begin
        pp_shifted = 64'd0;
        case (tag_out_k)
            2'd0:    pp_shifted = {32'd0, mc_p};
            2'd3:    pp_shifted = {mc_p, 32'd0};
            default: pp_shifted = {16'd0, mc_p, 16'd0};
        endcase
        acc_next = tag_out_v ? (acc_q + pp_shifted) : acc_q;
    end

    // Unsigned high word turned into signed high word by subtracting the other operand
    always_comb begin
        hi_fix = acc_q[63:32];
        if (op_q[1] && a_q[31]) begin
            hi_fix = hi_fix - b_q;
        end
        if ((op_q == 2'b11) && b_q[31]) begin
            hi_fix = hi_fix - a_q;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mc_en      = 1'b0;
        mc_a       = 16'd0;
        mc_b       = 16'd0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                busy  = 1'b1;
                mc_en = 1'b1;
                mc_a  = k_q[1] ? a_q[31:16] : a_q[15:0];
                mc_b  = k_q[0] ? b_q[31:16] : b_q[15:0];
                if (k_q == last_k) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (tag_out_v && (tag_out_k == last_k)) begin
                    state_next = is_mulx ? S_FIX : S_DONE;
                end
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = start ? S_ISSUE : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= 2'd0;
            k_q      <= 2'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            for (int i = 1; i <= MC_LATENCY; i++) begin
                tag_v[i] <= 1'b0;
                tag_k[i] <= 2'd0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                a_q   <= src1;
                b_q   <= src2;
                op_q  <= op;
                k_q   <= 2'd0;
                acc_q <= 64'd0;
            end else begin
                acc_q <= acc_next;
                if (issue) k_q <= k_q + 2'd1;
            end
            if (state == S_FIX) begin
                result_q <= hi_fix;
            end else if ((state == S_DRAIN) && (state_next == S_DONE)) begin
                result_q <= acc_next[31:0];
            end
            tag_v[1] <= issue;
            tag_k[1] <= k_q;
            for (int i = 2; i <= MC_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_k[i] <= tag_k[i-1];
            end
        end
    end

    assign result = result_q;

endmodule
